// File: rtl/eth_tx_frame_arbiter.sv
// rtl/eth_tx_frame_arbiter.sv - two-requester round-robin frame arbiter feeding the MAC tx stream
// Define ETH_TX_ARB_WATCHDOG_EN to enable the stall watchdog and the ABORT/DRAIN recovery path.
module eth_tx_frame_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int STALL_TIMEOUT = 256
) (
  input  logic                  tx_clk,
  input  logic                  tx_rst_n,
  input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
  input  logic                  s0_axis_tvalid,
  output logic                  s0_axis_tready,
  input  logic                  s0_axis_tlast,
  input  logic                  s0_axis_tuser,
  input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
  input  logic                  s1_axis_tvalid,
  output logic                  s1_axis_tready,
  input  logic                  s1_axis_tlast,
  input  logic                  s1_axis_tuser,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic [1:0]            grant,
  output logic [1:0]            frame_done,
  output logic [7:0]            abort_count
);

  typedef enum logic [1:0] {IDLE, ACTIVE, ABORT, DRAIN} state_t;

  state_t state;
  logic   rr;

  logic                  sel;
  logic [DATA_WIDTH-1:0] g_tdata;
  logic                  g_tvalid;
  logic                  g_tlast;
  logic                  g_tuser;
  logic                  beat;

  // grant is one-hot, so bit 1 alone selects the owning requester
  assign sel      = grant[1];
  assign g_tdata  = sel ? s1_axis_tdata  : s0_axis_tdata;
  assign g_tvalid = sel ? s1_axis_tvalid : s0_axis_tvalid;
  assign g_tlast  = sel ? s1_axis_tlast  : s0_axis_tlast;
  assign g_tuser  = sel ? s1_axis_tuser  : s0_axis_tuser;
  assign beat     = (state == ACTIVE) && g_tvalid && m_axis_tready;

  always_comb begin
    m_axis_tvalid  = 1'b0;
    m_axis_tdata   = '0;
    m_axis_tlast   = 1'b0;
    m_axis_tuser   = 1'b0;
    s0_axis_tready = 1'b0;
    s1_axis_tready = 1'b0;
    if (tx_rst_n) begin
      case (state)
        ACTIVE: begin
          m_axis_tvalid  = g_tvalid;
          m_axis_tdata   = g_tdata;
          m_axis_tlast   = g_tlast;
          m_axis_tuser   = g_tuser;
          s0_axis_tready = grant[0] & m_axis_tready;
          s1_axis_tready = grant[1] & m_axis_tready;
        end
        ABORT: begin
          m_axis_tvalid = 1'b1;
          m_axis_tlast  = 1'b1;
          m_axis_tuser  = 1'b1;
        end
        DRAIN: begin
          s0_axis_tready = grant[0];
          s1_axis_tready = grant[1];
        end
        default: ;
      endcase
    end
  end

`ifdef ETH_TX_ARB_WATCHDOG_EN
  logic [15:0] wdog;

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state       <= IDLE;
      grant       <= 2'b00;
      rr          <= 1'b0;
      frame_done  <= 2'b00;
      wdog        <= '0;
      abort_count <= 8'd0;
    end else begin
      frame_done <= 2'b00;
      case (state)
        IDLE: begin
          wdog <= '0;
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            if (s0_axis_tvalid && (!s1_axis_tvalid || !rr)) begin
              grant <= 2'b01;
              rr    <= 1'b1;
            end else begin
              grant <= 2'b10;
              rr    <= 1'b0;
            end
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (beat && g_tlast) begin
            frame_done <= grant;
            grant      <= 2'b00;
            state      <= IDLE;
          end else if (beat) begin
            wdog <= '0;
          end else if (!g_tvalid) begin
            // only an empty upstream counts; MAC backpressure never trips the watchdog
            if (wdog == 16'(STALL_TIMEOUT - 1)) state <= ABORT;
            wdog <= wdog + 16'd1;
          end
        end
        ABORT: begin
          if (m_axis_tready) begin
            state <= DRAIN;
            if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
          end
        end
        DRAIN: begin
          if (g_tvalid && g_tlast) begin
            frame_done <= grant;
            grant      <= 2'b00;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`else
  assign abort_count = 8'd0;

  always_ff @(posedge tx_clk) begin
    if (!tx_rst_n) begin
      state      <= IDLE;
      grant      <= 2'b00;
      rr         <= 1'b0;
      frame_done <= 2'b00;
    end else begin
      frame_done <= 2'b00;
      case (state)
        IDLE: begin
          if (s0_axis_tvalid || s1_axis_tvalid) begin
            if (s0_axis_tvalid && (!s1_axis_tvalid || !rr)) begin
              grant <= 2'b01;
              rr    <= 1'b1;
            end else begin
              grant <= 2'b10;
              rr    <= 1'b0;
            end
            state <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (beat && g_tlast) begin
            frame_done <= grant;
            grant      <= 2'b00;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// tb/tb_eth_tx_frame_arbiter.sv - scoreboard bench for eth_tx_frame_arbiter with a frame-level reference model
module tb_eth_tx_frame_arbiter;
  localparam int DW = 8;
  localparam int ST = 16;
`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam bit WD_EN = 1'b1;
`else
  localparam bit WD_EN = 1'b0;
`endif

  typedef struct { logic [DW-1:0] data; logic last; logic user; int gap; } beat_t;
  typedef struct { logic [DW-1:0] data; logic last; logic user; int port; bit is_abort; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [DW-1:0] s_tdata [2];
  logic s_tvalid [2];
  logic s_tlast [2];
  logic s_tuser [2];
  logic s_tready [2];
  logic [DW-1:0] m_tdata;
  logic m_tvalid, m_tready, m_tlast, m_tuser;
  logic [1:0] grant, frame_done;
  logic [7:0] abort_count;

  beat_t src_q [2][$];
  beat_t mq [2][$];
  exp_t exp_q [$];
  int exp_done [$];
  int checks = 0, failures = 0, cyc = 0, last_pop_cyc = 0;
  int model_rr = 0, model_aborts = 0, mode = 1;

  eth_tx_frame_arbiter #(.DATA_WIDTH(DW), .STALL_TIMEOUT(ST)) dut (
    .tx_clk(clk), .tx_rst_n(rst_n),
    .s0_axis_tdata(s_tdata[0]), .s0_axis_tvalid(s_tvalid[0]), .s0_axis_tready(s_tready[0]),
    .s0_axis_tlast(s_tlast[0]), .s0_axis_tuser(s_tuser[0]),
    .s1_axis_tdata(s_tdata[1]), .s1_axis_tvalid(s_tvalid[1]), .s1_axis_tready(s_tready[1]),
    .s1_axis_tlast(s_tlast[1]), .s1_axis_tuser(s_tuser[1]),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
    .m_axis_tlast(m_tlast), .m_axis_tuser(m_tuser),
    .grant(grant), .frame_done(frame_done), .abort_count(abort_count)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void gen_frame(input int p, input int len, input int maxgap);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = DW'($urandom);
      b.last = (i == len - 1);
      b.user = ($urandom_range(0, 7) == 0);
      b.gap  = (i == 0) ? 0 : int'($urandom_range(0, maxgap));
      src_q[p].push_back(b);
      mq[p].push_back(b);
    end
  endfunction

  // Frame-level arbitration: rr picks on contention, a gap of ST idle cycles aborts the frame.
  function automatic void model_run();
    beat_t b;
    exp_t e;
    int p;
    bit aborted, first;
    while (mq[0].size() > 0 || mq[1].size() > 0) begin
      if (mq[0].size() > 0 && mq[1].size() > 0) p = model_rr;
      else p = (mq[0].size() > 0) ? 0 : 1;
      model_rr = 1 - p;
      aborted = 1'b0;
      first = 1'b1;
      while (1) begin
        b = mq[p].pop_front();
        if (!first && !aborted && WD_EN && b.gap >= ST) begin
          e.data = '0; e.last = 1'b1; e.user = 1'b1; e.port = p; e.is_abort = 1'b1;
          exp_q.push_back(e);
          aborted = 1'b1;
          if (model_aborts < 255) model_aborts++;
        end
        if (!aborted) begin
          e.data = b.data; e.last = b.last; e.user = b.user; e.port = p; e.is_abort = 1'b0;
          exp_q.push_back(e);
        end
        first = 1'b0;
        if (b.last) break;
      end
      exp_done.push_back(p);
    end
  endfunction

  task automatic drive(input int p);
    bit acc;
    int gap_left;
    acc = 1'b0;
    gap_left = -1;
    s_tvalid[p] = 1'b0; s_tdata[p] = '0; s_tlast[p] = 1'b0; s_tuser[p] = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (acc) begin
        void'(src_q[p].pop_front());
        gap_left = -1;
      end
      if (src_q[p].size() == 0) begin
        s_tvalid[p] = 1'b0;
      end else begin
        if (gap_left < 0) gap_left = src_q[p][0].gap;
        if (gap_left > 0) begin
          s_tvalid[p] = 1'b0;
          gap_left--;
        end else begin
          s_tvalid[p] = 1'b1;
          s_tdata[p]  = src_q[p][0].data;
          s_tlast[p]  = src_q[p][0].last;
          s_tuser[p]  = src_q[p][0].user;
        end
      end
      @(negedge clk);
      acc = s_tvalid[p] && s_tready[p];
    end
  endtask

  initial drive(0);
  initial drive(1);

  initial begin
    m_tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (mode)
        0: m_tready = 1'b0;
        1: m_tready = 1'b1;
        2: m_tready = ($urandom_range(0, 3) != 0);
        default: m_tready = ~m_tready;
      endcase
    end
  end

  initial begin : monitor
    exp_t e;
    int pd;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst_n === 1'b1) begin
        chk("tready_only_granted", {30'd0, s_tready[1] & ~grant[1], s_tready[0] & ~grant[0]}, 0);
        if (m_tvalid && m_tready) begin
          if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_beat: got data %0h with no beat expected (cycle %0d)", m_tdata, cyc);
          end else begin
            e = exp_q.pop_front();
            chk("m_tdata", m_tdata, e.data);
            chk("m_tlast", m_tlast, e.last);
            chk("m_tuser", m_tuser, e.user);
            chk("beat_grant", grant, 1 << e.port);
            if (e.is_abort)
              chk("abort_latency", (cyc - last_pop_cyc >= ST) && (cyc - last_pop_cyc <= ST + 2), 1);
            last_pop_cyc = cyc;
          end
        end
        if (frame_done != 2'b00) begin
          if (exp_done.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_frame_done: got %0b with none expected (cycle %0d)", frame_done, cyc);
          end else begin
            pd = exp_done.pop_front();
            chk("frame_done", frame_done, 1 << pd);
          end
        end
      end
    end
  end

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() > 0 || exp_done.size() > 0) && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    chk({name, "_complete"}, (exp_q.size() == 0 && exp_done.size() == 0), 1);
    if (exp_q.size() > 0 || exp_done.size() > 0) begin
      exp_q.delete(); exp_done.delete();
      src_q[0].delete(); src_q[1].delete();
    end
    repeat (3) @(negedge clk);
    #1;
    chk({name, "_abort_count"}, abort_count, model_aborts);
  endtask

  initial begin : main
    int n0, n1, n;
    rst_n = 1'b0;
    mode = 1;
    // both requesters valid straight out of reset
    for (int k = 0; k < 2; k++) begin
      gen_frame(0, 4, 0);
      gen_frame(1, 4, 0);
    end
    model_run();
    repeat (3) begin
      @(negedge clk);
      chk("rst_s0_tready", s_tready[0], 0);
      chk("rst_s1_tready", s_tready[1], 0);
      chk("rst_m_tvalid", m_tvalid, 0);
      chk("rst_grant", grant, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_abort_count", abort_count, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    wait_done("both_rr", 300);

    for (int k = 0; k < 3; k++) gen_frame(1, $urandom_range(1, 6), 2);
    model_run();
    wait_done("port1_only", 300);

    mode = 2;
    for (int it = 0; it < 6; it++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range((n0 == 0) ? 1 : 0, 3);
      for (int i = 0; i < n0; i++) gen_frame(0, $urandom_range(1, 8), 3);
      for (int i = 0; i < n1; i++) gen_frame(1, $urandom_range(1, 8), 3);
      model_run();
      wait_done("random", 1000);
    end

    mode = 3;
    for (int k = 0; k < 3; k++) begin
      gen_frame(0, 80, 0);
      gen_frame(1, 80, 0);
    end
    model_run();
    wait_done("toggle_ready", 3000);

    mode = 1;
    gen_frame(0, 6, 0);
    src_q[0][2].gap = 20;
    mq[0][2].gap = 20;
    model_run();
    wait_done("stall", 300);

    // reset in the middle of a port 1 frame
    gen_frame(1, 8, 0);
    model_run();
    n = 0;
    while (exp_q.size() > 6 && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    mode = 0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_reset_grant", grant, 2'b10);
    exp_q.delete();
    exp_done.delete();
    mq[1] = src_q[1];
    gen_frame(0, 4, 0);
    model_rr = 0;
    model_aborts = 0;
    model_run();
    mode = 1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_m_tvalid", m_tvalid, 0);
    chk("midrst_s0_tready", s_tready[0], 0);
    chk("midrst_s1_tready", s_tready[1], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_grant", grant, 0);
    chk("post_rst_m_tvalid", m_tvalid, 0);
    chk("post_rst_frame_done", frame_done, 0);
    wait_done("after_reset", 300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
